// File: rtl/load_sequencer.sv
// Multi-cycle MIPS load controller: word-aligned memory read over req/ack,
// byte/halfword lane select, sign/zero extension and register write-back.
module load_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int REG_BITS   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            load_type,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [REG_BITS-1:0]   dest_reg,
    output logic                  busy,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic                  rf_we,
    output logic [REG_BITS-1:0]   rf_waddr,
    output logic [31:0]           rf_wdata,
    output logic                  load_fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    state_t      state;
    state_t      state_next;
    logic [2:0]  type_q;
    logic [1:0]  lane_q;
    logic        start_bad;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] ext_data;

    // Reject illegal opcodes and misaligned halfword/word addresses up front
    always_comb begin
        start_bad = 1'b1;
        case (load_type)
            LT_LB, LT_LBU: start_bad = 1'b0;
            LT_LH, LT_LHU: start_bad = addr[0];
            LT_LW:         start_bad = (addr[1:0] != 2'b00);
            default:       start_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = start_bad ? ERR : REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_next = WB;
                end
            end
            WB:      state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign busy       = (state != IDLE);
    assign mem_req    = (state == REQ);
    assign load_fault = (state == ERR);
    // Writes to r0 are suppressed but the read itself still happens
    assign rf_we      = (state == WB) && (rf_waddr != '0);

    always_comb begin
        byte_lane = mem_rdata[7:0];
        case (lane_q)
            2'd0:    byte_lane = mem_rdata[7:0];
            2'd1:    byte_lane = mem_rdata[15:8];
            2'd2:    byte_lane = mem_rdata[23:16];
            2'd3:    byte_lane = mem_rdata[31:24];
            default: byte_lane = mem_rdata[7:0];
        endcase
        half_lane = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        ext_data = mem_rdata;
        case (type_q)
            LT_LB:   ext_data = {{24{byte_lane[7]}}, byte_lane};
            LT_LBU:  ext_data = {24'd0, byte_lane};
            LT_LH:   ext_data = {{16{half_lane[15]}}, half_lane};
            LT_LHU:  ext_data = {16'd0, half_lane};
            default: ext_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= '0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            type_q   <= '0;
            lane_q   <= '0;
        end else begin
            if (state == IDLE && start) begin
                mem_addr <= {addr[ADDR_WIDTH-1:2], 2'b00};
                rf_waddr <= dest_reg;
                type_q   <= load_type;
                lane_q   <= addr[1:0];
            end
            if (state == REQ && mem_ack) begin
                rf_wdata <= ext_data;
            end
        end
    end

endmodule
